cla_pipe_addsub: RTL and testbench

CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

---
 rtl/cla_pipe_addsub.sv | 149 ++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract built from 4-bit carry-lookahead groups, split evenly over STAGES slices.
// Optional macro CLA_SATURATE_EN clamps the sum to the signed limit on overflow.
module cla_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / 4;

    // Returns {carry_out, sum} for one slice of NG lookahead groups.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                               input logic c_in);
        logic [SW-1:0] g, p, c;
        logic [NG-1:0] gg, gp;
        logic [NG:0]   gc;
        logic          term;
        g = x & y;
        p = x ^ y;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        // Each group carry is a flat sum of products over all lower groups and the slice carry-in.
        gc    = '0;
        gc[0] = c_in;
        for (int j = 0; j < NG; j++) begin
            for (int i = -1; i <= j; i++) begin
                if (i < 0) term = c_in;
                else       term = gg[i];
                for (int m = i + 1; m <= j; m++) term = term & gp[m];
                gc[j+1] = gc[j+1] | term;
            end
        end
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        return {gc[NG], p ^ c};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [WIDTH-1:0] fin_sum;
    logic [WIDTH-1:0] sum_next;
    logic             fin_v, fin_c, fin_a_msb, fin_b_msb, ovf_next;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO = gi * SW;
            logic [WIDTH-LO-1:0] in_a, in_b;
            logic [LO+SW-1:0]    acc_sum;
            logic                sl_c, sl_v;
            logic [SW:0]         sl_res;

            if (gi == 0) begin : g_src
                assign in_a    = a;
                assign in_b    = b_eff;
                assign sl_c    = c0;
                assign sl_v    = in_valid;
                assign acc_sum = sl_res[SW-1:0];
            end else begin : g_src
                assign in_a    = g_stage[gi-1].g_reg.rest_a_reg;
                assign in_b    = g_stage[gi-1].g_reg.rest_b_reg;
                assign sl_c    = g_stage[gi-1].g_reg.carry_reg;
                assign sl_v    = g_stage[gi-1].g_reg.valid_reg;
                assign acc_sum = {sl_res[SW-1:0], g_stage[gi-1].g_reg.sum_reg};
            end

            assign sl_res = cla_slice(in_a[SW-1:0], in_b[SW-1:0], sl_c);

            // Non-final slices register their carry, finished sum bits and the still-pending operands.
            if (gi < STAGES - 1) begin : g_reg
                logic                   valid_reg, carry_reg;
                logic [LO+SW-1:0]       sum_reg;
                logic [WIDTH-LO-SW-1:0] rest_a_reg, rest_b_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        valid_reg  <= 1'b0;
                        carry_reg  <= 1'b0;
                        sum_reg    <= '0;
                        rest_a_reg <= '0;
                        rest_b_reg <= '0;
                    end else if (adv) begin
                        valid_reg  <= sl_v;
                        carry_reg  <= sl_res[SW];
                        sum_reg    <= acc_sum;
                        rest_a_reg <= in_a[WIDTH-LO-1:SW];
                        rest_b_reg <= in_b[WIDTH-LO-1:SW];
                    end
                end
            end
        end
    endgenerate

    assign fin_sum   = g_stage[STAGES-1].acc_sum;
    assign fin_v     = g_stage[STAGES-1].sl_v;
    assign fin_c     = g_stage[STAGES-1].sl_res[SW];
    assign fin_a_msb = g_stage[STAGES-1].in_a[SW-1];
    assign fin_b_msb = g_stage[STAGES-1].in_b[SW-1];
    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    assign ovf_next  = fin_c ^ (fin_sum[WIDTH-1] ^ fin_a_msb ^ fin_b_msb);

`ifdef CLA_SATURATE_EN
    assign sum_next = !ovf_next ? fin_sum :
                      fin_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign sum_next = fin_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= fin_v;
            sum       <= sum_next;
            cout      <= fin_c;
            ovf       <= ovf_next;
        end
    end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed cases, stall, mid-stream reset and random traffic
// checked cycle by cycle against an arithmetic transaction model.
module tb_cla_pipe_addsub;
    localparam int W = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    int           checks = 0;
    int           errors = 0;
    int           hs_cnt = 0;
    logic         mv [S];
    logic [W+1:0] md [S];
    logic         last_adv;
    logic         started = 1'b0;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Expected {ovf, cout, sum} from signed/unsigned integer arithmetic.
    function automatic logic [W+1:0] ref_calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic c, input logic s);
        longint       sx, sy, r_s, lim;
        logic [W-1:0] res;
        logic         co, ov;
        lim = longint'(1) << (W - 1);
        sx  = longint'(x);
        sy  = longint'(y);
        if (x[W-1]) sx = sx - 2 * lim;
        if (y[W-1]) sy = sy - 2 * lim;
        if (s) begin
            r_s = sx - sy;
            co  = (x >= y);
        end else begin
            r_s = sx + sy + longint'(c);
            co  = (longint'(x) + longint'(y) + longint'(c)) >= 2 * lim;
        end
        res = r_s[W-1:0];
        ov  = (r_s >= lim) || (r_s < -lim);
`ifdef CLA_SATURATE_EN
        if (ov) res = (r_s > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        return {ov, co, res};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check in_ready, advance the model at the edge, check outputs.
    task automatic do_cycle(input logic r, input logic v, input logic [W-1:0] xa,
                            input logic [W-1:0] xb, input logic xc, input logic xs,
                            input logic ordy);
        rst = r; in_valid = v; a = xa; b = xb; cin = xc; sub = xs; out_ready = ordy;
        last_adv = ordy || !mv[S-1];
        #2;
        if (started) chk("in_ready", 64'(in_ready), 64'(last_adv));
        if (out_valid === 1'b1 && ordy) hs_cnt++;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < S; k++) mv[k] = 1'b0;
        end else if (last_adv) begin
            for (int k = S - 1; k > 0; k--) begin
                mv[k] = mv[k-1];
                md[k] = md[k-1];
            end
            mv[0] = v;
            md[0] = ref_calc(xa, xb, xc, xs);
        end
        #1;
        started = 1'b1;
        chk("out_valid", 64'(out_valid), 64'(mv[S-1]));
        if (mv[S-1]) chk("result", 64'({ovf, cout, sum}), 64'(md[S-1]));
    endtask

    logic [W-1:0] d_a [5];
    logic [W-1:0] d_b [5];
    logic         d_c [5];
    logic         d_s [5];
    logic [W+1:0] d_e [5];
    logic [W-1:0] st_a [5];
    logic [W-1:0] st_b [5];
    logic         st_c [5];
    logic         st_s [5];
    logic [W-1:0] corner [4];
    logic [W-1:0] ra, rb;
    logic         ordy, v;
    int           idx, stall_left, lat;

    initial begin
        for (int k = 0; k < S; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end

        // Reset, with an input offered during reset that must be ignored.
        do_cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        chk("rst_data", 64'({ovf, cout, sum}), 64'd0);

        // Directed corner transactions with literal expectations {ovf, cout, sum}.
        d_a[0] = 16'h7FFF; d_b[0] = 16'h0001; d_c[0] = 1'b0; d_s[0] = 1'b0;
        d_a[1] = 16'h0005; d_b[1] = 16'h0007; d_c[1] = 1'b0; d_s[1] = 1'b1;
        d_a[2] = 16'h8000; d_b[2] = 16'h0001; d_c[2] = 1'b0; d_s[2] = 1'b1;
        d_a[3] = 16'hFFFF; d_b[3] = 16'h0000; d_c[3] = 1'b1; d_s[3] = 1'b0;
        d_a[4] = 16'h0003; d_b[4] = 16'h0001; d_c[4] = 1'b1; d_s[4] = 1'b1;
`ifdef CLA_SATURATE_EN
        d_e[0] = {1'b1, 1'b0, 16'h7FFF};
        d_e[2] = {1'b1, 1'b1, 16'h8000};
`else
        d_e[0] = {1'b1, 1'b0, 16'h8000};
        d_e[2] = {1'b1, 1'b1, 16'h7FFF};
`endif
        d_e[1] = {1'b0, 1'b0, 16'hFFFE};
        d_e[3] = {1'b0, 1'b1, 16'h0000};
        d_e[4] = {1'b0, 1'b1, 16'h0002};
        for (int i = 0; i < 5 + S; i++) begin
            if (i < 5) do_cycle(1'b0, 1'b1, d_a[i], d_b[i], d_c[i], d_s[i], 1'b1);
            else       do_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            if (i >= S - 1 && i - (S - 1) < 5)
                chk("directed", 64'({ovf, cout, sum}), 64'(d_e[i-(S-1)]));
        end

        // Four back-to-back transactions, output stalled 3 cycles once the first result shows.
        for (int i = 0; i < 5; i++) begin
            st_a[i] = W'($urandom());
            st_b[i] = W'($urandom());
            st_c[i] = 1'($urandom_range(0, 1));
            st_s[i] = 1'($urandom_range(0, 1));
        end
        hs_cnt = 0; idx = 0; stall_left = 3;
        for (int cyc = 0; cyc < 30 && hs_cnt < 4; cyc++) begin
            ordy = 1'b1;
            if (mv[S-1] && stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end
            v = (idx < 4);
            do_cycle(1'b0, v, st_a[idx], st_b[idx], st_c[idx], st_s[idx], ordy);
            if (v && last_adv) idx++;
        end
        chk("stall_results", 64'(hs_cnt), 64'd4);
        do_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Reset with two transactions in flight, then a fresh transaction straight after.
        do_cycle(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        do_cycle(1'b0, 1'b1, 16'h00F0, 16'h000F, 1'b1, 1'b0, 1'b1);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            do_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            lat++;
        end
        chk("rst_recover_latency", 64'(lat), 64'(S));
        chk("rst_recover_sum", 64'(sum), 64'h0100);
        repeat (3) do_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Random traffic: bubbles, back-pressure, occasional reset and corner operands.
        corner[0] = 16'h0000; corner[1] = 16'h7FFF; corner[2] = 16'h8000; corner[3] = 16'hFFFF;
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom());
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom());
            do_cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), ra, rb,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0));
        end
        repeat (S + 2) do_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
